// File: rtl/spatz_vrf_write_arbiter.sv
// rtl/spatz_vrf_write_arbiter.sv - one-slot-per-client arbiter onto a single VRF write port
module spatz_vrf_write_arbiter #(
    parameter int NrClients = 3,
    parameter int AddrWidth = 7,
    parameter int DataWidth = 128
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            prio_mode_i,
    input  logic [NrClients-1:0]            client_valid_i,
    output logic [NrClients-1:0]            client_ready_o,
    input  logic [NrClients*AddrWidth-1:0]  client_waddr_i,
    input  logic [NrClients*DataWidth-1:0]  client_wdata_i,
    input  logic [NrClients*DataWidth/8-1:0] client_wbe_i,
    output logic [NrClients-1:0]            client_done_o,
    output logic                            vrf_we_o,
    output logic [AddrWidth-1:0]            vrf_waddr_o,
    output logic [DataWidth-1:0]            vrf_wdata_o,
    output logic [DataWidth/8-1:0]          vrf_wbe_o,
    input  logic                            vrf_wvalid_i
);

    localparam int BeWidth = DataWidth / 8;
    localparam int IdxW    = $clog2(NrClients);

    logic [NrClients-1:0] r_full;
    logic [NrClients-1:0] r_done;
    logic [AddrWidth-1:0] r_addr [NrClients];
    logic [DataWidth-1:0] r_data [NrClients];
    logic [BeWidth-1:0]   r_be   [NrClients];
    logic [IdxW-1:0]      r_rr;
    logic [IdxW-1:0]      r_lock_idx;
    logic                 r_locked;
    logic                 r_lock_mode;

    logic                 w_any;
    logic                 w_commit;
    logic                 w_mode;
    logic [IdxW-1:0]      w_grant;
    logic [IdxW-1:0]      w_pick_fix;
    logic [IdxW-1:0]      w_pick_rr;
    logic [IdxW-1:0]      w_rr_next;
    logic [NrClients-1:0] w_accept;

    // First full slot at or after ptr, wrapping around the client ring.
    function automatic logic [IdxW-1:0] f_rr_pick(input logic [NrClients-1:0] full,
                                                  input logic [IdxW-1:0]      ptr);
        logic [IdxW-1:0] pick;
        logic [IdxW-1:0] cand;
        logic            found;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NrClients; i++) begin
            cand = IdxW'((int'(ptr) + i) % NrClients);
            if (!found && full[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        return pick;
    endfunction

    always_comb begin
        w_pick_fix = '0;
        for (int k = NrClients - 1; k >= 0; k--) begin
            if (r_full[k]) w_pick_fix = IdxW'(k);
        end
    end

    assign w_pick_rr = f_rr_pick(r_full, r_rr);

    // A locked grant keeps the mode it was arbitrated under, so a mode flip waits for commit.
    assign w_mode    = r_locked ? r_lock_mode : prio_mode_i;
    assign w_grant   = r_locked ? r_lock_idx : (w_mode ? w_pick_fix : w_pick_rr);
    assign w_any     = (|r_full) && !rst_i;
    assign w_commit  = w_any && vrf_wvalid_i;
    assign w_rr_next = (w_grant == IdxW'(NrClients - 1)) ? '0 : w_grant + 1'b1;

    assign client_ready_o = ~r_full & {NrClients{~rst_i}};
    assign client_done_o  = r_done & {NrClients{~rst_i}};
    assign w_accept       = client_valid_i & client_ready_o;

    assign vrf_we_o    = w_any;
    assign vrf_waddr_o = w_any ? r_addr[w_grant] : '0;
    assign vrf_wdata_o = w_any ? r_data[w_grant] : '0;
    assign vrf_wbe_o   = w_any ? r_be[w_grant]   : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_full      <= '0;
            r_done      <= '0;
            r_rr        <= '0;
            r_locked    <= 1'b0;
            r_lock_idx  <= '0;
            r_lock_mode <= 1'b0;
        end else begin
            r_done <= '0;
            if (w_commit) begin
                r_full[w_grant] <= 1'b0;
                r_done[w_grant] <= 1'b1;
                r_locked        <= 1'b0;
                if (!w_mode) r_rr <= w_rr_next;
            end else if (w_any) begin
                r_locked    <= 1'b1;
                r_lock_idx  <= w_grant;
                r_lock_mode <= w_mode;
            end
            // Accepting slots are empty, so this never collides with the commit clear above.
            for (int k = 0; k < NrClients; k++) begin
                if (w_accept[k]) r_full[k] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NrClients; k++) begin
            if (w_accept[k]) begin
                r_addr[k] <= client_waddr_i[k*AddrWidth +: AddrWidth];
                r_data[k] <= client_wdata_i[k*DataWidth +: DataWidth];
                r_be[k]   <= client_wbe_i[k*BeWidth +: BeWidth];
            end
        end
    end

endmodule

// File: tb/tb_spatz_vrf_write_arbiter.sv
// tb/tb_spatz_vrf_write_arbiter.sv - directed and random checks of the VRF write arbiter
module tb_spatz_vrf_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 7;
    localparam int DW = 128;
    localparam int BW = DW / 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              prio_mode_i;
    logic [N-1:0]      client_valid_i;
    logic [N-1:0]      client_ready_o;
    logic [N*AW-1:0]   client_waddr_i;
    logic [N*DW-1:0]   client_wdata_i;
    logic [N*BW-1:0]   client_wbe_i;
    logic [N-1:0]      client_done_o;
    logic              vrf_we_o;
    logic [AW-1:0]     vrf_waddr_o;
    logic [DW-1:0]     vrf_wdata_o;
    logic [BW-1:0]     vrf_wbe_o;
    logic              vrf_wvalid_i;

    spatz_vrf_write_arbiter #(.NrClients(N), .AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .prio_mode_i    (prio_mode_i),
        .client_valid_i (client_valid_i),
        .client_ready_o (client_ready_o),
        .client_waddr_i (client_waddr_i),
        .client_wdata_i (client_wdata_i),
        .client_wbe_i   (client_wbe_i),
        .client_done_o  (client_done_o),
        .vrf_we_o       (vrf_we_o),
        .vrf_waddr_o    (vrf_waddr_o),
        .vrf_wdata_o    (vrf_wdata_o),
        .vrf_wbe_o      (vrf_wbe_o),
        .vrf_wvalid_i   (vrf_wvalid_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: each client owns a pending write; the port serves one per cycle by the stated rules.
    bit            m_pend [N];
    logic [AW-1:0] m_addr [N];
    logic [DW-1:0] m_data [N];
    logic [BW-1:0] m_be   [N];
    int            m_rr;
    bit            m_locked;
    int            m_lock_client;
    bit            m_lock_mode;
    logic [N-1:0]  m_done;

    logic [N-1:0]  obs_ready, obs_done;
    logic          obs_we;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_data;
    int            done_log[$];
    logic [DW-1:0] data_log[$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input bit fixed_mode);
        for (int i = 0; i < N; i++) begin
            int c = fixed_mode ? i : (m_rr + i) % N;
            if (m_pend[c]) return c;
        end
        return 0;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input int k, input bit v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] b);
        client_valid_i[k]          = v;
        client_waddr_i[k*AW +: AW] = a;
        client_wdata_i[k*DW +: DW] = d;
        client_wbe_i[k*BW +: BW]   = b;
    endtask

    task automatic cycle();
        bit            any;
        bit            effm;
        int            g;
        logic [N-1:0]  e_ready;
        logic [N-1:0]  e_done;
        @(negedge clk_i);
        any = 1'b0;
        for (int k = 0; k < N; k++) if (m_pend[k]) any = 1'b1;
        if (rst_i) any = 1'b0;
        effm = m_locked ? m_lock_mode : prio_mode_i;
        g    = m_locked ? m_lock_client : pick(effm);
        for (int k = 0; k < N; k++) e_ready[k] = !rst_i && !m_pend[k];
        e_done = rst_i ? '0 : m_done;

        obs_ready = client_ready_o;
        obs_done  = client_done_o;
        obs_we    = vrf_we_o;
        obs_addr  = vrf_waddr_o;
        obs_data  = vrf_wdata_o;
        chk("ready", DW'(client_ready_o), DW'(e_ready));
        chk("done",  DW'(client_done_o),  DW'(e_done));
        chk("we",    DW'(vrf_we_o),       DW'(any));
        chk("waddr", DW'(vrf_waddr_o),    any ? DW'(m_addr[g]) : '0);
        chk("wdata", vrf_wdata_o,         any ? m_data[g] : '0);
        chk("wbe",   DW'(vrf_wbe_o),      any ? DW'(m_be[g]) : '0);
        for (int k = 0; k < N; k++) if (client_done_o[k]) done_log.push_back(k);
        if (!rst_i && vrf_we_o && vrf_wvalid_i) data_log.push_back(vrf_wdata_o);

        if (rst_i) begin
            for (int k = 0; k < N; k++) m_pend[k] = 1'b0;
            m_rr = 0; m_locked = 1'b0; m_done = '0;
        end else begin
            m_done = '0;
            if (any && vrf_wvalid_i) begin
                m_pend[g] = 1'b0;
                m_done[g] = 1'b1;
                if (!effm) m_rr = (g + 1) % N;
                m_locked = 1'b0;
            end else if (any) begin
                m_locked = 1'b1; m_lock_client = g; m_lock_mode = effm;
            end
            for (int k = 0; k < N; k++) begin
                if (client_valid_i[k] && e_ready[k]) begin
                    m_pend[k] = 1'b1;
                    m_addr[k] = client_waddr_i[k*AW +: AW];
                    m_data[k] = client_wdata_i[k*DW +: DW];
                    m_be[k]   = client_wbe_i[k*BW +: BW];
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        client_valid_i = '0;
        cycle();
        chk("rst_ready", DW'(obs_ready), '0);
        chk("rst_we", DW'(obs_we), '0);
        cycle();
        rst_i = 1'b0;
        done_log.delete();
        data_log.delete();
    endtask

    logic [DW-1:0] d0, d1, d2;
    int base;
    bit found;

    initial begin
        rst_i = 1'b1; prio_mode_i = 1'b0; vrf_wvalid_i = 1'b0;
        client_valid_i = '0; client_waddr_i = '0; client_wdata_i = '0; client_wbe_i = '0;
        for (int k = 0; k < N; k++) begin
            m_pend[k] = 1'b0; m_addr[k] = '0; m_data[k] = '0; m_be[k] = '0;
        end
        m_rr = 0; m_locked = 1'b0; m_lock_client = 0; m_lock_mode = 1'b0; m_done = '0;
        @(posedge clk_i); #1;

        // Single write from client 1
        do_reset();
        vrf_wvalid_i = 1'b1;
        drive(1, 1'b1, 7'h05, {16{8'hA5}}, '1);
        cycle();
        chk("t1_ready_after_reset", DW'(obs_ready), DW'(3'b111));
        client_valid_i = '0;
        cycle();
        chk("t1_we", DW'(obs_we), DW'(1));
        chk("t1_addr", DW'(obs_addr), DW'(7'h05));
        chk("t1_data", obs_data, {16{8'hA5}});
        cycle();
        chk("t1_done", DW'(obs_done), DW'(3'b010));
        cycle();
        chk("t1_done_once", DW'(obs_done), '0);

        // Round-robin, all three loaded together, twice
        do_reset();
        prio_mode_i = 1'b0; vrf_wvalid_i = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < N; k++) drive(k, 1'b1, AW'(k + 8), rand_data(), '1);
            cycle();
            client_valid_i = '0;
            repeat (5) cycle();
        end
        chk("t2_count", DW'(done_log.size()), DW'(6));
        if (done_log.size() == 6)
            for (int i = 0; i < 6; i++) chk("t2_order", DW'(done_log[i]), DW'(i % 3));

        // Fixed priority with all clients refilling, then switch to round-robin
        do_reset();
        prio_mode_i = 1'b1; vrf_wvalid_i = 1'b0;
        for (int k = 0; k < N; k++) drive(k, 1'b1, AW'($urandom), rand_data(), BW'($urandom));
        cycle();
        vrf_wvalid_i = 1'b1;
        repeat (8) begin
            for (int k = 0; k < N; k++) drive(k, 1'b1, AW'($urandom), rand_data(), BW'($urandom));
            cycle();
        end
        prio_mode_i = 1'b0;
        base = done_log.size();
        repeat (8) begin
            for (int k = 0; k < N; k++) drive(k, 1'b1, AW'($urandom), rand_data(), BW'($urandom));
            cycle();
        end
        found = 1'b0;
        for (int i = base + 1; i < base + 4 && i < done_log.size(); i++)
            if (done_log[i] == 1) found = 1'b1;
        chk("t3_c1_within_3", DW'(found), DW'(1));

        // Stall while client 2 holds the grant; client 0 loads meanwhile
        do_reset();
        prio_mode_i = 1'b0; vrf_wvalid_i = 1'b0;
        d2 = rand_data(); d0 = rand_data();
        drive(2, 1'b1, 7'h22, d2, '1);
        cycle();
        drive(2, 1'b0, '0, '0, '0);
        drive(0, 1'b1, 7'h10, d0, '1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            client_valid_i = '0;
            chk("t4_hold_addr", DW'(obs_addr), DW'(7'h22));
            chk("t4_hold_data", obs_data, d2);
        end
        vrf_wvalid_i = 1'b1;
        repeat (3) cycle();
        chk("t4_count", DW'(data_log.size()), DW'(2));
        if (data_log.size() == 2) begin
            chk("t4_first", data_log[0], d2);
            chk("t4_second", data_log[1], d0);
        end

        // Reset during a locked grant
        do_reset();
        vrf_wvalid_i = 1'b0;
        drive(1, 1'b1, 7'h33, rand_data(), '1);
        cycle();
        client_valid_i = '0;
        repeat (2) cycle();
        rst_i = 1'b1;
        cycle();
        chk("t5_we_in_rst", DW'(obs_we), '0);
        rst_i = 1'b0;
        cycle();
        chk("t5_we_after", DW'(obs_we), '0);
        chk("t5_ready_after", DW'(obs_ready), DW'(3'b111));
        vrf_wvalid_i = 1'b1;
        cycle();
        chk("t5_no_done", DW'(done_log.size()), '0);

        // Commit and new valid on client 0 in the same cycle
        do_reset();
        vrf_wvalid_i = 1'b1;
        d0 = rand_data(); d1 = rand_data();
        drive(0, 1'b1, 7'h01, d0, '1);
        cycle();
        drive(0, 1'b1, 7'h02, d1, '1);
        cycle();
        chk("t6_ready_at_commit", DW'(obs_ready[0]), '0);
        cycle();
        chk("t6_ready_next", DW'(obs_ready[0]), DW'(1));
        client_valid_i = '0;
        repeat (3) cycle();
        chk("t6_count", DW'(data_log.size()), DW'(2));
        if (data_log.size() == 2) begin
            chk("t6_first", data_log[0], d0);
            chk("t6_second", data_log[1], d1);
        end

        // Random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_i = ($urandom_range(0, 255) == 0);
            if ($urandom_range(0, 15) == 0) prio_mode_i = ~prio_mode_i;
            vrf_wvalid_i = ($urandom_range(0, 9) < 7);
            for (int k = 0; k < N; k++)
                drive(k, 1'($urandom_range(0, 1)), AW'($urandom), rand_data(), BW'($urandom));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
